// File: rtl/ps2_pkg.sv
// Shared types and Set-2 scan-code constants for the PS/2 scan-code decoder.
package ps2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_BREAK,
      ST_EXT,
      ST_EXT_BREAK,
      ST_SKIP
   } state_e;

   localparam logic [7:0] SC_BREAK   = 8'hF0;
   localparam logic [7:0] SC_EXT     = 8'hE0;
   localparam logic [7:0] SC_PAUSE   = 8'hE1;
   localparam logic [7:0] SC_SHIFT_L = 8'h12;
   localparam logic [7:0] SC_SHIFT_R = 8'h59;
   localparam logic [7:0] SC_CTRL    = 8'h14;
   localparam logic [7:0] SC_CAPS    = 8'h58;

   // Bytes following E1 that belong to the Pause make sequence.
   localparam logic [2:0] PAUSE_SKIP_LEN = 3'd7;

endpackage

// File: rtl/ps2_scancode_decoder_if.sv
// Byte-in / character-out bundle between the PS/2 receiver, the decoder and the keyboard register.
interface ps2_scancode_decoder_if;
   logic [7:0] scanCode;
   logic       scanCodeReady;
   logic [7:0] ascii;
   logic       asciiValid;
   logic       asciiReady;
   logic       capsLock;
   logic       overflow;

   modport master (
      output scanCode, scanCodeReady, asciiReady,
      input  ascii, asciiValid, capsLock, overflow
   );

   modport slave (
      input  scanCode, scanCodeReady, asciiReady,
      output ascii, asciiValid, capsLock, overflow
   );
endinterface

// File: rtl/ps2_set2_ascii_rom.sv
// Combinational Set-2 make-code to ASCII lookup with shift, caps and ctrl applied.
module ps2_set2_ascii_rom (
   input  logic [7:0] code_i,
   input  logic       shift_i,
   input  logic       caps_i,
   input  logic       ctrl_i,
   output logic [7:0] ascii_o,
   output logic       mapped_o
);
   logic [17:0] ent_s;
   logic        letter_s;
   logic [7:0]  lo_s;
   logic [7:0]  hi_s;

   // Table entry: {mapped, letter, unshifted char, shifted char}.
   always_comb begin
      case (code_i)
         8'h1C: ent_s = {2'b11, 8'h61, 8'h41};
         8'h32: ent_s = {2'b11, 8'h62, 8'h42};
         8'h21: ent_s = {2'b11, 8'h63, 8'h43};
         8'h23: ent_s = {2'b11, 8'h64, 8'h44};
         8'h24: ent_s = {2'b11, 8'h65, 8'h45};
         8'h2B: ent_s = {2'b11, 8'h66, 8'h46};
         8'h34: ent_s = {2'b11, 8'h67, 8'h47};
         8'h33: ent_s = {2'b11, 8'h68, 8'h48};
         8'h43: ent_s = {2'b11, 8'h69, 8'h49};
         8'h3B: ent_s = {2'b11, 8'h6A, 8'h4A};
         8'h42: ent_s = {2'b11, 8'h6B, 8'h4B};
         8'h4B: ent_s = {2'b11, 8'h6C, 8'h4C};
         8'h3A: ent_s = {2'b11, 8'h6D, 8'h4D};
         8'h31: ent_s = {2'b11, 8'h6E, 8'h4E};
         8'h44: ent_s = {2'b11, 8'h6F, 8'h4F};
         8'h4D: ent_s = {2'b11, 8'h70, 8'h50};
         8'h15: ent_s = {2'b11, 8'h71, 8'h51};
         8'h2D: ent_s = {2'b11, 8'h72, 8'h52};
         8'h1B: ent_s = {2'b11, 8'h73, 8'h53};
         8'h2C: ent_s = {2'b11, 8'h74, 8'h54};
         8'h3C: ent_s = {2'b11, 8'h75, 8'h55};
         8'h2A: ent_s = {2'b11, 8'h76, 8'h56};
         8'h1D: ent_s = {2'b11, 8'h77, 8'h57};
         8'h22: ent_s = {2'b11, 8'h78, 8'h58};
         8'h35: ent_s = {2'b11, 8'h79, 8'h59};
         8'h1A: ent_s = {2'b11, 8'h7A, 8'h5A};
         8'h16: ent_s = {2'b10, 8'h31, 8'h21};
         8'h1E: ent_s = {2'b10, 8'h32, 8'h40};
         8'h26: ent_s = {2'b10, 8'h33, 8'h23};
         8'h25: ent_s = {2'b10, 8'h34, 8'h24};
         8'h2E: ent_s = {2'b10, 8'h35, 8'h25};
         8'h36: ent_s = {2'b10, 8'h36, 8'h5E};
         8'h3D: ent_s = {2'b10, 8'h37, 8'h26};
         8'h3E: ent_s = {2'b10, 8'h38, 8'h2A};
         8'h46: ent_s = {2'b10, 8'h39, 8'h28};
         8'h45: ent_s = {2'b10, 8'h30, 8'h29};
         8'h0E: ent_s = {2'b10, 8'h60, 8'h7E};
         8'h4E: ent_s = {2'b10, 8'h2D, 8'h5F};
         8'h55: ent_s = {2'b10, 8'h3D, 8'h2B};
         8'h54: ent_s = {2'b10, 8'h5B, 8'h7B};
         8'h5B: ent_s = {2'b10, 8'h5D, 8'h7D};
         8'h5D: ent_s = {2'b10, 8'h5C, 8'h7C};
         8'h4C: ent_s = {2'b10, 8'h3B, 8'h3A};
         8'h52: ent_s = {2'b10, 8'h27, 8'h22};
         8'h41: ent_s = {2'b10, 8'h2C, 8'h3C};
         8'h49: ent_s = {2'b10, 8'h2E, 8'h3E};
         8'h4A: ent_s = {2'b10, 8'h2F, 8'h3F};
         8'h29: ent_s = {2'b10, 8'h20, 8'h20};
         8'h5A: ent_s = {2'b10, 8'h0D, 8'h0D};
         8'h66: ent_s = {2'b10, 8'h08, 8'h08};
         8'h0D: ent_s = {2'b10, 8'h09, 8'h09};
         8'h76: ent_s = {2'b10, 8'h1B, 8'h1B};
         default: ent_s = 18'd0;
      endcase
   end

   assign {mapped_o, letter_s, lo_s, hi_s} = ent_s;

   // Ctrl folds letters onto 0x01-0x1A; caps only flips letter case.
   always_comb begin
      if (letter_s) begin
         if (ctrl_i) begin
            ascii_o = lo_s - 8'h60;
         end else if (shift_i ^ caps_i) begin
            ascii_o = hi_s;
         end else begin
            ascii_o = lo_s;
         end
      end else if (shift_i) begin
         ascii_o = hi_s;
      end else begin
         ascii_o = lo_s;
      end
   end
endmodule

// File: rtl/ps2_scancode_decoder.sv
// Set-2 scan-code stream to ASCII: prefix FSM, modifier tracking, one-stage lookup and character FIFO.
module ps2_scancode_decoder
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input logic                   clk,
   input logic                   rst,
   ps2_scancode_decoder_if.slave bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   state_e      state_q, state_d;
   logic [2:0]  skip_q, skip_d;
   logic        shift_l_q, shift_l_d, shift_r_q, shift_r_d;
   logic        ctrl_l_q, ctrl_l_d, ctrl_r_q, ctrl_r_d;
   logic        caps_held_q, caps_held_d, caps_lock_q, caps_lock_d;
   logic        emit_q, emit_d;
   logic [7:0]  emit_char_q, emit_char_d;
   logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic        overflow_q, overflow_d;
   logic [7:0]  fifo_q [FIFO_DEPTH];

   logic        make_s, brk_s, ext_s, key_s;
   logic [7:0]  code_s, rom_ascii_s;
   logic        rom_mapped_s;
   logic        empty_s, full_s, pop_s, push_s;

   assign code_s = bus.scanCode;

   ps2_set2_ascii_rom u_rom (
      .code_i   (code_s),
      .shift_i  (shift_l_q | shift_r_q),
      .caps_i   (caps_lock_q),
      .ctrl_i   (ctrl_l_q | ctrl_r_q),
      .ascii_o  (rom_ascii_s),
      .mapped_o (rom_mapped_s)
   );

   // Prefix FSM: classify each received byte as make/break, normal/extended, or swallowed.
   always_comb begin
      state_d = state_q;
      skip_d  = skip_q;
      make_s  = 1'b0;
      brk_s   = 1'b0;
      ext_s   = 1'b0;
      if (bus.scanCodeReady) begin
         case (state_q)
            ST_IDLE: begin
               if (code_s == SC_BREAK) begin
                  state_d = ST_BREAK;
               end else if (code_s == SC_EXT) begin
                  state_d = ST_EXT;
               end else if (code_s == SC_PAUSE) begin
                  state_d = ST_SKIP;
                  skip_d  = PAUSE_SKIP_LEN;
               end else begin
                  make_s = 1'b1;
               end
            end
            ST_BREAK: begin
               brk_s   = 1'b1;
               state_d = ST_IDLE;
            end
            ST_EXT: begin
               if (code_s == SC_BREAK) begin
                  state_d = ST_EXT_BREAK;
               end else begin
                  make_s  = 1'b1;
                  ext_s   = 1'b1;
                  state_d = ST_IDLE;
               end
            end
            ST_EXT_BREAK: begin
               brk_s   = 1'b1;
               ext_s   = 1'b1;
               state_d = ST_IDLE;
            end
            ST_SKIP: begin
               skip_d = skip_q - 3'd1;
               if (skip_q == 3'd1) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_SKIP;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Modifier state and lookup register; the ROM sees modifiers as they were before this byte.
   always_comb begin
      key_s       = make_s | brk_s;
      shift_l_d   = (key_s && !ext_s && code_s == SC_SHIFT_L) ? make_s : shift_l_q;
      shift_r_d   = (key_s && !ext_s && code_s == SC_SHIFT_R) ? make_s : shift_r_q;
      ctrl_l_d    = (key_s && !ext_s && code_s == SC_CTRL) ? make_s : ctrl_l_q;
      ctrl_r_d    = (key_s && ext_s && code_s == SC_CTRL) ? make_s : ctrl_r_q;
      caps_held_d = (key_s && !ext_s && code_s == SC_CAPS) ? make_s : caps_held_q;
      caps_lock_d = caps_lock_q ^ (make_s && !ext_s && code_s == SC_CAPS && !caps_held_q);
      emit_d      = make_s && !ext_s && rom_mapped_s;
      emit_char_d = rom_ascii_s;
   end

   // FIFO control: a pop frees the slot a same-cycle push into a full FIFO needs.
   always_comb begin
      empty_s    = (wr_ptr_q == rd_ptr_q);
      full_s     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      pop_s      = !empty_s && bus.asciiReady;
      push_s     = emit_q && (!full_s || pop_s);
      wr_ptr_d   = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
      rd_ptr_d   = pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
      overflow_d = overflow_q | (emit_q && full_s && !pop_s);
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         skip_q      <= 3'd0;
         shift_l_q   <= 1'b0;
         shift_r_q   <= 1'b0;
         ctrl_l_q    <= 1'b0;
         ctrl_r_q    <= 1'b0;
         caps_held_q <= 1'b0;
         caps_lock_q <= 1'b0;
         emit_q      <= 1'b0;
         emit_char_q <= 8'h00;
         wr_ptr_q    <= {(AW+1){1'b0}};
         rd_ptr_q    <= {(AW+1){1'b0}};
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         skip_q      <= skip_d;
         shift_l_q   <= shift_l_d;
         shift_r_q   <= shift_r_d;
         ctrl_l_q    <= ctrl_l_d;
         ctrl_r_q    <= ctrl_r_d;
         caps_held_q <= caps_held_d;
         caps_lock_q <= caps_lock_d;
         emit_q      <= emit_d;
         emit_char_q <= emit_char_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         overflow_q  <= overflow_d;
      end
   end

   // Character storage; contents are don't-care outside the valid window.
   always_ff @(posedge clk) begin
      if (push_s) begin
         fifo_q[wr_ptr_q[AW-1:0]] <= emit_char_q;
      end
   end

   assign bus.ascii      = empty_s ? 8'h00 : fifo_q[rd_ptr_q[AW-1:0]];
   assign bus.asciiValid = !empty_s;
   assign bus.capsLock   = caps_lock_q;
   assign bus.overflow   = overflow_q;
endmodule
